// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the cycle sequencer: Gray-coded cycle encodings
// (identical to the ones CsDecoder decodes), sequencer state encodings and
// the instruction group / operator codes.
package cycle_sequencer_pkg;

  // Gray-coded cycle encodings, in stepping order
  localparam logic [3:0] CYCLE_0  = 4'b0000;
  localparam logic [3:0] CYCLE_1  = 4'b0001;
  localparam logic [3:0] CYCLE_2  = 4'b0011;
  localparam logic [3:0] CYCLE_3  = 4'b0010;
  localparam logic [3:0] CYCLE_4  = 4'b0110;
  localparam logic [3:0] CYCLE_5  = 4'b0111;
  localparam logic [3:0] CYCLE_6  = 4'b0101;
  localparam logic [3:0] CYCLE_7  = 4'b0100;
  localparam logic [3:0] CYCLE_8  = 4'b1100;
  localparam logic [3:0] CYCLE_9  = 4'b1101;
  localparam logic [3:0] CYCLE_10 = 4'b1111;
  localparam logic [3:0] CYCLE_11 = 4'b1110;
  localparam logic [3:0] CYCLE_12 = 4'b1010;
  localparam logic [3:0] CYCLE_13 = 4'b1011;
  localparam logic [3:0] CYCLE_14 = 4'b1001;
  localparam logic [3:0] CYCLE_15 = 4'b1000;

  // Sequencer states; SEQ_HALT is only reachable in single-step builds
  typedef enum logic [1:0] {
    SEQ_RUN   = 2'b00,
    SEQ_HALT  = 2'b01,
    SEQ_ERROR = 2'b10
  } seq_state_e;

  // Instruction group codes from the instruction decoder
  localparam logic [3:0] BRANCH_JUMPS  = 4'h0;
  localparam logic [3:0] SINGLE_REG    = 4'h1;
  localparam logic [3:0] MATH_CONSTANT = 4'h2;
  localparam logic [3:0] MATH_REG      = 4'h3;
  localparam logic [3:0] REG_MEMORY    = 4'h4;
  localparam logic [3:0] STACK         = 4'h5;
  localparam logic [3:0] EXTENDED      = 4'h6;

  // Operator codes of group EXTENDED
  localparam logic [3:0] OP_JMP = 4'h0;

endpackage

// File: rtl/cycle_sequencer_gray_step.sv
// gray_step: combinational successor of a 4-bit Gray-coded cycle.
// CYCLE_15 wraps to CYCLE_0.
module gray_step
  import cycle_sequencer_pkg::*;
(
  input  logic [3:0] cur,
  output logic [3:0] nxt
);

  // Table lookup of the next Gray code in cycle order
  always_comb begin
    nxt = CYCLE_0;
    case (cur)
      CYCLE_0:  nxt = CYCLE_1;
      CYCLE_1:  nxt = CYCLE_2;
      CYCLE_2:  nxt = CYCLE_3;
      CYCLE_3:  nxt = CYCLE_4;
      CYCLE_4:  nxt = CYCLE_5;
      CYCLE_5:  nxt = CYCLE_6;
      CYCLE_6:  nxt = CYCLE_7;
      CYCLE_7:  nxt = CYCLE_8;
      CYCLE_8:  nxt = CYCLE_9;
      CYCLE_9:  nxt = CYCLE_10;
      CYCLE_10: nxt = CYCLE_11;
      CYCLE_11: nxt = CYCLE_12;
      CYCLE_12: nxt = CYCLE_13;
      CYCLE_13: nxt = CYCLE_14;
      CYCLE_14: nxt = CYCLE_15;
      CYCLE_15: nxt = CYCLE_0;
      default:  nxt = CYCLE_0;
    endcase
  end

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: steps the Gray-coded control-store cycle, inserts memory
// wait states, ends each instruction on its group's last cycle and flags bus
// timeouts (sticky, cleared only by reset).
// Optional feature macro: SEQ_SINGLE_STEP_EN adds halt_req/step/halted and a
// HALT state for single-stepping instructions.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 15,
  parameter int WAIT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        operator_group,
  input  logic [3:0]        operator,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic [3:0]        cycle,
  output logic              instr_done,
  output logic              stall,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              bus_error
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic              halt_req,
  input  logic              step,
  output logic              halted
`endif
);

  localparam logic              TIMEOUT_EN  = (WAIT_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(WAIT_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = {WAIT_W{1'b1}};

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [3:0]        cycle_r;
  logic [3:0]        cycle_nxt_s;
  logic [3:0]        gray_nxt_s;
  logic [3:0]        last_s;
  logic [WAIT_W-1:0] wait_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic [WAIT_W-1:0] wait_inc_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              stall_s;
  logic              timeout_s;
  logic              at_last_s;
  logic              retire_s;

  gray_step u_gray_step (
    .cur (cycle_r),
    .nxt (gray_nxt_s)
  );

  // Last cycle of the instruction for the current group; below CYCLE_3 no
  // group ever matches, so an instruction cannot end before CYCLE_3
  always_comb begin
    last_s = CYCLE_3;
    case (operator_group)
      SINGLE_REG, MATH_CONSTANT, MATH_REG, REG_MEMORY, STACK: last_s = CYCLE_5;
      EXTENDED: begin
        // OP_JMP is the only defined operator; undefined ones end alike
        if (operator == OP_JMP) begin
          last_s = CYCLE_8;
        end else begin
          last_s = CYCLE_8;
        end
      end
      default: last_s = CYCLE_3;
    endcase
  end

  assign stall_s    = mem_req & ~mem_ready & (state_r == SEQ_RUN);
  assign wait_inc_s = (wait_r == WAIT_MAX) ? wait_r : (wait_r + WAIT_W'(1));
  assign timeout_s  = stall_s & TIMEOUT_EN & (wait_inc_s == TIMEOUT_VAL);
  // CYCLE_15 always ends the instruction so a bad group cannot lock us up
  assign at_last_s  = (cycle_r == last_s) | (cycle_r == CYCLE_15);
  assign retire_s   = (state_r == SEQ_RUN) & ~stall_s & at_last_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEQ_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: timeout traps into ERROR, halt requests take effect
  // only when the current instruction retires
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEQ_RUN: begin
        if (timeout_s) begin
          state_nxt_s = SEQ_ERROR;
`ifdef SEQ_SINGLE_STEP_EN
        end else if (retire_s && halt_req) begin
          state_nxt_s = SEQ_HALT;
`endif
        end else begin
          state_nxt_s = SEQ_RUN;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      SEQ_HALT: begin
        // A step runs one instruction; halt_req still high re-halts at its end
        if (step || !halt_req) begin
          state_nxt_s = SEQ_RUN;
        end else begin
          state_nxt_s = SEQ_HALT;
        end
      end
`endif
      SEQ_ERROR: state_nxt_s = SEQ_ERROR;
      default:   state_nxt_s = SEQ_ERROR;
    endcase
  end

  // Next cycle / wait count / done pulse for the current state
  always_comb begin
    cycle_nxt_s = cycle_r;
    wait_nxt_s  = wait_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      SEQ_RUN: begin
        if (stall_s) begin
          wait_nxt_s = wait_inc_s;
        end else if (at_last_s) begin
          wait_nxt_s  = {WAIT_W{1'b0}};
          cycle_nxt_s = CYCLE_0;
          done_nxt_s  = 1'b1;
        end else begin
          wait_nxt_s  = {WAIT_W{1'b0}};
          cycle_nxt_s = gray_nxt_s;
        end
      end
      SEQ_HALT: begin
        cycle_nxt_s = CYCLE_0;
        wait_nxt_s  = {WAIT_W{1'b0}};
      end
      SEQ_ERROR: begin
        cycle_nxt_s = cycle_r;
        wait_nxt_s  = wait_r;
      end
      default: begin
        cycle_nxt_s = cycle_r;
        wait_nxt_s  = wait_r;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r <= CYCLE_0;
      wait_r  <= {WAIT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      cycle_r <= cycle_nxt_s;
      wait_r  <= wait_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign cycle      = cycle_r;
  assign instr_done = done_r;
  assign wait_cnt   = wait_r;
  assign stall      = stall_s;
  assign bus_error  = (state_r == SEQ_ERROR);
`ifdef SEQ_SINGLE_STEP_EN
  assign halted     = (state_r == SEQ_HALT);
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer. A behavioural model tracks the
// cycle as a position 0..15 in the Gray order and derives the Gray code
// arithmetically; every clock the DUT outputs are compared against it.
module tb_cycle_sequencer;

  localparam int TO = 4;
  localparam int WW = 4;
`ifdef SEQ_SINGLE_STEP_EN
  localparam bit HAS_STEP = 1'b1;
`else
  localparam bit HAS_STEP = 1'b0;
`endif

  localparam logic [3:0] G_BRANCH   = 4'h0;
  localparam logic [3:0] G_SINGLE   = 4'h1;
  localparam logic [3:0] G_MCONST   = 4'h2;
  localparam logic [3:0] G_MREG     = 4'h3;
  localparam logic [3:0] G_REGMEM   = 4'h4;
  localparam logic [3:0] G_STACK    = 4'h5;
  localparam logic [3:0] G_EXT      = 4'h6;
  localparam logic [3:0] G_UNLISTED = 4'hF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b1;
  logic          halt_req = 1'b0;
  logic          step = 1'b0;
  logic [3:0]    operator_group = 4'h3;
  logic [3:0]    operator_code = 4'h0;
  logic [3:0]    cycle;
  logic          instr_done;
  logic          stall;
  logic          bus_error;
  logic          halted;
  logic [WW-1:0] wait_cnt;

  cycle_sequencer #(.WAIT_TIMEOUT(TO), .WAIT_W(WW)) dut (
    .clk            (clk),
    .reset          (reset),
    .operator_group (operator_group),
    .operator       (operator_code),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .cycle          (cycle),
    .instr_done     (instr_done),
    .stall          (stall),
    .wait_cnt       (wait_cnt),
    .bus_error      (bus_error)
`ifdef SEQ_SINGLE_STEP_EN
    ,
    .halt_req       (halt_req),
    .step           (step),
    .halted         (halted)
`endif
  );
`ifndef SEQ_SINGLE_STEP_EN
  assign halted = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model state
  int m_idx = 0;
  int m_wait = 0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  bit m_halt = 1'b0;
  bit stall_seen, stall_exp;
  int n_checks = 0;
  int n_fail = 0;

  function automatic int last_idx(input logic [3:0] g);
    case (g)
      G_SINGLE, G_MCONST, G_MREG, G_REGMEM, G_STACK: return 5;
      G_EXT:   return 8;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] gray_of(input int i);
    int b;
    b = i & 15;
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic logic [11:0] obs_vec();
    return {cycle, instr_done, wait_cnt, bus_error, halted, stall_seen};
  endfunction

  function automatic logic [11:0] exp_vec();
    return {gray_of(m_idx), m_done, WW'(m_wait), m_err, m_halt, stall_exp};
  endfunction

  // Apply one clock of the sequencing rules to the model
  task automatic model_step();
    if (reset) begin
      m_idx = 0; m_wait = 0; m_done = 0; m_err = 0; m_halt = 0;
    end else if (m_err) begin
      m_done = 0;
    end else if (m_halt) begin
      m_done = 0; m_idx = 0; m_wait = 0;
      if (step || !halt_req) m_halt = 0;
    end else if (mem_req && !mem_ready) begin
      m_done = 0;
      if (m_wait < (1 << WW) - 1) m_wait = m_wait + 1;
      if (TO != 0 && m_wait == TO) m_err = 1;
    end else begin
      m_wait = 0;
      if (m_idx == 15 || m_idx == last_idx(operator_group)) begin
        m_idx = 0; m_done = 1;
        if (HAS_STEP && halt_req) m_halt = 1;
      end else begin
        m_idx = m_idx + 1; m_done = 0;
      end
    end
  endtask

  // One clock: sample the combinational stall before the edge, update model
  task automatic tick();
    @(negedge clk);
    stall_seen = stall;
    stall_exp  = mem_req && !mem_ready && !m_err && !m_halt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_req = 1'b0; mem_ready = 1'b1; halt_req = 1'b0; step = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      mem_req = 1'($urandom); mem_ready = 1'($urandom); operator_group = 4'($urandom);
      tick();
    end
    n_checks++;
    if ({cycle, instr_done, wait_cnt, bus_error, halted} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_values: got %b want 00000000000", {cycle, instr_done, wait_cnt, bus_error, halted});
    end
    reset = 1'b0;
  endtask

  task automatic test_math_reg();
    logic [3:0] seq [7] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001};
    int dones = 0;
    do_reset();
    operator_group = G_MREG; mem_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 6) dones += int'(instr_done);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL math_reg_model clk %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (cycle !== seq[i] || instr_done !== (i == 5)) begin
        n_fail++; $display("FAIL math_reg_seq clk %0d: cycle %b done %b want %b %b", i, cycle, instr_done, seq[i], i == 5);
      end
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL math_reg_done_count: got %0d want 1", dones);
    end
  endtask

  // EXTENDED with three wait clocks on CYCLE_5: done lands on tick 12,
  // i.e. the 13th clock counting the initial CYCLE_0
  task automatic test_wait_states();
    int stalls = 0;
    int ticks = 0;
    do_reset();
    operator_group = G_EXT; operator_code = 4'($urandom);
    while (ticks < 30) begin
      mem_req   = (m_idx == 5);
      mem_ready = !(m_idx == 5 && stalls < 3);
      if (m_idx == 5 && stalls < 3) stalls++;
      tick(); ticks++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wait_states_model tick %0d: got %b want %b", ticks, obs_vec(), exp_vec());
      end
      if (instr_done) break;
    end
    n_checks++;
    if (ticks !== 12 || instr_done !== 1'b1) begin
      n_fail++; $display("FAIL wait_states_length: got %0d ticks done=%b want 12 ticks done=1", ticks, instr_done);
    end
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    operator_group = G_MREG;
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin mem_req = 1'b0; mem_ready = 1'b1; end
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL timeout_model clk %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus_error !== 1'b1 || cycle !== 4'b0001 || wait_cnt !== 4'd4) begin
      n_fail++; $display("FAIL timeout_frozen: err %b cycle %b wait %0d want 1 0001 4", bus_error, cycle, wait_cnt);
    end
    do_reset();
    n_checks++;
    if (bus_error !== 1'b0 || cycle !== 4'b0000 || wait_cnt !== 4'd0) begin
      n_fail++; $display("FAIL timeout_reset: err %b cycle %b wait %0d want 0 0000 0", bus_error, cycle, wait_cnt);
    end
  endtask

  task automatic test_short_groups();
    logic [3:0] grp [2] = '{G_BRANCH, G_UNLISTED};
    for (int g = 0; g < 2; g++) begin
      int last_done = 0;
      do_reset();
      operator_group = grp[g];
      for (int i = 1; i <= 8; i++) begin
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL short_group_model grp %h clk %0d: got %b want %b", grp[g], i, obs_vec(), exp_vec());
        end
        if (instr_done) begin
          n_checks++;
          if (i - last_done !== 4) begin
            n_fail++; $display("FAIL short_group_len grp %h: got %0d want 4", grp[g], i - last_done);
          end
          last_done = i;
        end
      end
      n_checks++;
      if (last_done !== 8) begin
        n_fail++; $display("FAIL short_group_end grp %h: last done at %0d want 8", grp[g], last_done);
      end
    end
  endtask

  task automatic test_zero_wait();
    int dones = 0;
    do_reset();
    operator_group = G_STACK; mem_req = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      dones += int'(instr_done);
      n_checks++;
      if (obs_vec() !== exp_vec() || stall_seen !== 1'b0) begin
        n_fail++; $display("FAIL zero_wait clk %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (dones !== 2 || cycle !== 4'b0000) begin
      n_fail++; $display("FAIL zero_wait_count: dones %0d cycle %b want 2 0000", dones, cycle);
    end
    mem_req = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    operator_group = G_MREG;
    repeat (2) tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({cycle, instr_done, wait_cnt, bus_error} !== 10'b0) begin
      n_fail++; $display("FAIL reset_mid_wait: got %b want 0000000000", {cycle, instr_done, wait_cnt, bus_error});
    end
    reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = m_err || ($urandom_range(0, 63) == 0);
      if (m_idx == 0) operator_group = 4'($urandom);
      operator_code = 4'($urandom);
      mem_req   = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random clk %0d grp %h: got %b want %b", i, operator_group, obs_vec(), exp_vec());
      end
    end
    reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int n = 0;
    int dones = 0;
    do_reset();
    operator_group = G_MREG;
    repeat (3) tick();
    halt_req = 1'b1;
    while (n < 20 && !halted) begin
      tick(); n++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL halt_model clk %0d: got %b want %b", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (halted !== 1'b1 || n !== 3) begin
      n_fail++; $display("FAIL halt_entry: halted %b after %0d clocks want 1 after 3", halted, n);
    end
    repeat (3) tick();
    n_checks++;
    if (obs_vec() !== exp_vec() || cycle !== 4'b0000 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold: got %b want %b", obs_vec(), exp_vec());
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    n = 0;
    while (n < 20 && !halted) begin
      tick(); n++;
      dones += int'(instr_done);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL step_model clk %0d: got %b want %b", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (dones !== 1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL step_one_instr: dones %0d halted %b want 1 1", dones, halted);
    end
    halt_req = 1'b0;
    tick();
    n_checks++;
    if (halted !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_release: got %b want %b", obs_vec(), exp_vec());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_math_reg();
    test_wait_states();
    test_timeout();
    test_short_groups();
    test_zero_wait();
    test_reset_mid_wait();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
